// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU data-memory arbiter: default widths,
// arbiter FSM state encoding and an index-width helper.
package gpu_mem_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot winner and its index.
module rr_pick
    import gpu_mem_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int cand;

    // NOTE: every output gets a default before the search loop so no path
    // through this block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = IDX_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one synchronous
// data RAM. Every output is a register updated from the next-state logic.
module data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t          state, next_state;
    logic [IDX_W-1:0]    ptr, ptr_d;
    logic [NUM_REQ-1:0]  sel, sel_d;
    logic [NUM_REQ-1:0]  gnt_d, rvalid_d;
    logic                we_d, re_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   din_d, rdata_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        next_state = state;
        ptr_d      = ptr;
        sel_d      = sel;
        gnt_d      = '0;
        rvalid_d   = '0;
        we_d       = 1'b0;
        re_d       = 1'b0;
        addr_d     = mem_addr;
        din_d      = mem_din;
        rdata_d    = rdata;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    sel_d      = pick_oh;
                    gnt_d      = pick_oh;
                    ptr_d      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    we_d       = req_we[pick_idx];
                    re_d       = !req_we[pick_idx];
                    addr_d     = addr_arr[pick_idx];
                    din_d      = wdata_arr[pick_idx];
                    next_state = ISSUE;
                end
            end
            // mem_we is the registered copy of the winner's write select.
            ISSUE: next_state = mem_we ? IDLE : RESP;
            // mem_dout is only looked at here, so Z/X elsewhere never propagates.
            RESP: begin
                rdata_d    = mem_dout;
                rvalid_d   = sel;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            rvalid   <= '0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rdata    <= '0;
        end else begin
            state    <= next_state;
            ptr      <= ptr_d;
            sel      <= sel_d;
            gnt      <= gnt_d;
            rvalid   <= rvalid_d;
            mem_we   <= we_d;
            mem_re   <= re_d;
            mem_addr <= addr_d;
            mem_din  <= din_d;
            rdata    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random
// traffic checked against a transaction-level round-robin/memory model.
module tb_data_mem_arbiter;
    import gpu_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_we, mem_re;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    wire  [DW-1:0]   mem_dout;

    always #5 clk = ~clk;

    data_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Synchronous RAM environment: registered read data, Z when not reading.
    logic [DW-1:0] seed_word;
    logic [DW-1:0] ram [256];
    bit            ram_ok [256];
    logic [DW-1:0] rd_q;
    logic          rd_pending = 1'b0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h10) ? 16'hBEEF : ({a, ~a} ^ seed_word);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_din;
            ram_ok[mem_addr] <= 1'b1;
        end
        rd_pending <= mem_re;
        if (mem_re) rd_q <= ram_ok[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end
    assign mem_dout = rd_pending ? rd_q : 'z;

    // Reference model state.
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_ptr;
    logic [DW-1:0] m_mem [256];
    logic [DW-1:0] m_rdata;
    bit            pend [N];
    bit            p_we [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("no_x", 64'($isunknown({gnt, rvalid, rdata, mem_we, mem_re, mem_addr, mem_din})), 64'd0);
        check("we_re_excl", 64'(mem_we & mem_re), 64'd0);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]                = pend[i];
            req_we[i]             = p_we[i];
            req_addr[i*AW +: AW]  = p_addr[i];
            req_wdata[i*DW +: DW] = p_wd[i];
        end
    endtask

    task automatic post(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        p_we[i]   = we;
        p_addr[i] = a;
        p_wd[i]   = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_mem_re", 64'(mem_re), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_din", 64'(mem_din), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        m_ptr   = 0;
        m_rdata = '0;
        tick();
        tick();
        check("rst_hold_rvalid", 64'(rvalid), 64'd0);
        rst_n = 1'b1;
    endtask

    // Serve one transaction: model picks the round-robin winner among pending
    // requesters; returns the index the DUT actually granted.
    task automatic serve(output int got);
        int            w;
        logic [N-1:0]  oh;
        logic [AW-1:0] a;
        bit            we;
        w   = -1;
        got = -1;
        for (int i = 0; i < N; i++)
            if (w < 0 && pend[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        if (w < 0) return;
        oh    = '0;
        oh[w] = 1'b1;
        a     = p_addr[w];
        we    = p_we[w];
        drive();
        tick();
        for (int i = 0; i < N; i++) if (gnt[i] === 1'b1 && got < 0) got = i;
        check("gnt", 64'(gnt), 64'(oh));
        check("mem_we", 64'(mem_we), 64'(we));
        check("mem_re", 64'(mem_re), 64'(!we));
        check("mem_addr", 64'(mem_addr), 64'(a));
        if (we) check("mem_din", 64'(mem_din), 64'(p_wd[w]));
        m_ptr   = (w + 1) % N;
        pend[w] = 1'b0;
        drive();
        if (we) begin
            m_mem[a] = p_wd[w];
            tick();
            check("wr_gnt_off", 64'(gnt), 64'd0);
            check("wr_we_off", 64'(mem_we), 64'd0);
            check("wr_addr_hold", 64'(mem_addr), 64'(a));
            check("wr_rdata_hold", 64'(rdata), 64'(m_rdata));
            check("wr_rvalid", 64'(rvalid), 64'd0);
        end else begin
            tick();
            check("resp_gnt", 64'(gnt), 64'd0);
            check("resp_re", 64'(mem_re), 64'd0);
            check("resp_rvalid", 64'(rvalid), 64'd0);
            check("resp_rdata_hold", 64'(rdata), 64'(m_rdata));
            tick();
            m_rdata = m_mem[a];
            check("rvalid", 64'(rvalid), 64'(oh));
            check("rdata", 64'(rdata), 64'(m_rdata));
        end
    endtask

    int           got;
    int           exp_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] oh3;

    initial begin
        seed_word = DW'($urandom);
        for (int a = 0; a < 256; a++) m_mem[a] = init_val(AW'(a));
        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
        end
        do_reset();

        // Idle with no requests: nothing granted.
        tick();
        check("idle_gnt", 64'(gnt), 64'd0);

        // Single read of a preloaded word.
        post(2, 1'b0, 8'h10, 16'h0);
        serve(got);
        check("rd_beef", 64'(rdata), 64'hBEEF);

        // Single write then readback by another requester.
        post(1, 1'b1, 8'h05, 16'h1234);
        serve(got);
        post(3, 1'b0, 8'h05, 16'h0);
        serve(got);
        check("rd_1234", 64'(rdata), 64'h1234);

        // All four requesting continuously from reset.
        do_reset();
        for (int i = 0; i < N; i++) post(i, 1'b0, AW'($urandom_range(0, 15)), 16'h0);
        for (int k = 0; k < 6; k++) begin
            serve(got);
            check("rr_order", 64'(got), 64'(exp_order[k]));
            post(got < 0 ? 0 : got, 1'b0, AW'($urandom_range(0, 15)), 16'h0);
        end

        // Same-cycle write by 0 and read by 1 to one address.
        do_reset();
        post(0, 1'b1, 8'h20, 16'hAAAA);
        post(1, 1'b0, 8'h20, 16'h0);
        serve(got);
        check("wr_first", 64'(got), 64'd0);
        serve(got);
        check("rd_second", 64'(got), 64'd1);
        check("rd_aaaa", 64'(rdata), 64'hAAAA);

        // Reset asserted during RESP of a read by requester 2.
        post(2, 1'b0, 8'h33, 16'h0);
        drive();
        tick();
        oh3 = 4'b0100;
        check("abort_gnt", 64'(gnt), 64'(oh3));
        pend[2] = 1'b0;
        drive();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_re", 64'(mem_re), 64'd0);
        check("abort_rvalid", 64'(rvalid), 64'd0);
        m_ptr   = 0;
        m_rdata = '0;
        tick();
        check("abort_rvalid2", 64'(rvalid), 64'd0);
        rst_n = 1'b1;
        tick();
        check("abort_rvalid3", 64'(rvalid), 64'd0);
        check("abort_gnt_off", 64'(gnt), 64'd0);
        post(1, 1'b0, 8'h33, 16'h0);
        post(3, 1'b0, 8'h34, 16'h0);
        serve(got);
        check("ptr_after_rst", 64'(got), 64'd1);
        serve(got);
        check("gnt3_alone", 64'(got), 64'd3);

        // Random traffic over a small address window to force collisions.
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    post(i, 1'($urandom_range(0, 1)), AW'(8'h40 + $urandom_range(0, 7)), DW'($urandom));
            if (!(pend[0] || pend[1] || pend[2] || pend[3]))
                post($urandom_range(0, N - 1), 1'b0, AW'(8'h40 + $urandom_range(0, 7)), 16'h0);
            serve(got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (1..8).
REQ-002 SHALL have parameter ADDR_W, default 8, data-memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, data-memory word width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester access request, held high until gnt.
REQ-008 SHALL have port req_we  input  NUM_REQ  per-requester write(1)/read(0) select.
REQ-009 SHALL have port req_addr  input  NUM_REQ*ADDR_W  packed per-requester address, requester i at slice i.
REQ-010 SHALL have port req_wdata  input  NUM_REQ*DATA_W  packed per-requester write data.
REQ-011 SHALL have port gnt  output  NUM_REQ  one-cycle grant pulse, one-hot.
REQ-012 SHALL have port rvalid  output  NUM_REQ  one-cycle read-data-valid pulse, one-hot.
REQ-013 SHALL have port rdata  output  DATA_W  read data, shared by all requesters.
REQ-014 SHALL have ports mem_we, mem_re  output  1 each  RAM write/read enables.
REQ-015 SHALL have ports mem_addr  output  ADDR_W and mem_din  output  DATA_W  RAM address and write data.
REQ-016 SHALL have port mem_dout  input  DATA_W  RAM registered read data, high-Z when not reading.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP; all outputs registered.
REQ-018 IDLE: when any req bit is high, SHALL pick winner by round-robin, latch winner index, req_we, req_addr, req_wdata, then go to ISSUE; otherwise stay in IDLE.
REQ-019 Round-robin: search starts at pointer and wraps modulo NUM_REQ; after each grant, pointer = (winner+1) mod NUM_REQ.
REQ-020 ISSUE (exactly one cycle): SHALL drive mem_addr/mem_din from the latches, assert mem_we (write) or mem_re (read), never both, and assert gnt[winner].
REQ-021 A write in ISSUE SHALL return to IDLE; a read SHALL go to RESP.
REQ-022 RESP: mem_we=mem_re=0; SHALL register mem_dout into rdata at the end of RESP, pulse rvalid[winner] in the following cycle (when the FSM is back in IDLE), and go to IDLE.
REQ-023 Latency: req seen in IDLE cycle T -> gnt in T+1 -> rvalid with rdata in T+3; one write per 2 cycles, one read per 3 cycles maximum.
REQ-024 mem_dout SHALL be sampled only in RESP; X/Z on it at any other time SHALL not affect any output.
REQ-025 rdata SHALL hold its last value until the next read completes.
REQ-026 req is sampled only in IDLE; a req dropped before gnt is not served; req inputs in ISSUE/RESP are ignored.
REQ-027 Write then read to the same address by any requesters SHALL return the new data (accesses strictly serialized).
REQ-028 mem_addr/mem_din SHALL hold their last values when no access is in progress.

Reset
REQ-029 On rst_n low, SHALL immediately force state=IDLE, pointer=0, gnt=0, rvalid=0, mem_we=0, mem_re=0, mem_addr=0, mem_din=0, rdata=0.
REQ-030 Reset during ISSUE or RESP SHALL abort the access with no gnt/rvalid afterwards; the first arbitration after release starts at requester 0.

Structure
REQ-031 ADDR_W/DATA_W defaults, NUM_REQ default and the FSM state enum SHALL live in shared package gpu_mem_pkg.
REQ-032 Round-robin selection (req, pointer -> one-hot winner, index) SHALL be sub-module rr_pick, purely combinational; FSM and latches stay in data_mem_arbiter.

Verification
REQ-033 Single read: req[2]=1, req_we=0, addr=8'h10, RAM[10]=16'hBEEF -> gnt[2] at T+1 with mem_re=1, mem_addr=8'h10; rvalid[2] and rdata=16'hBEEF at T+3.
REQ-034 Single write: req[1], req_we=1, addr=8'h05, wdata=16'h1234 -> gnt[1] with mem_we=1, mem_din=16'h1234 at T+1; readback by req[3] returns 16'h1234.
REQ-035 All four requesting continuously from reset -> grant order 0,1,2,3,0,1; no requester granted twice before the others.
REQ-036 Requester 0 writes 16'hAAAA to addr 8'h20 while requester 1 reads 8'h20 in the same IDLE cycle -> write granted first, read returns 16'hAAAA.
REQ-037 rst_n low during RESP of a read -> mem_re=0, rvalid never pulses for it; after release req[3] alone -> gnt[3] and pointer=0 for next arbitration.
REQ-038 mem_dout driven to Z outside RESP -> rdata unchanged, no X on any output.
